// File: rtl/altivec_wb_checker.sv
// altivec_wb_checker
//
// Write-back protocol checker for the VSFX datapath. Each channel records
// an issue (VRA, VRB and instruction enables all high while chk_en is high)
// and requires exactly one VRT write-enable LATENCY cycles later. Missing
// and spurious write-enables are reported as registered one-cycle pulses,
// a sticky error flag and saturating issue/error counters.
//
// Ports
//   clk           clock, all logic on posedge
//   rst           synchronous active-high reset
//   chk_en        global check enable (gates issue capture and spurious check)
//   vsfx_vra_en   per-channel VRA read enable
//   vsfx_vrb_en   per-channel VRB read enable
//   vsfx_ins_en   per-channel instruction valid
//   vsfx_vrt_en   per-channel VRT write enable
//   err_missing   per-channel pulse: expected vrt_en absent
//   err_spurious  per-channel pulse: vrt_en without expectation
//   err_sticky    set on any error, cleared only by rst
//   issue_count   saturating count of recorded issues
//   err_count     saturating count of flagged errors
module altivec_wb_checker #(
   parameter int NUM_CH  = 2,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16,
   parameter int MSG_EN  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              chk_en,
   input  logic [NUM_CH-1:0] vsfx_vra_en,
   input  logic [NUM_CH-1:0] vsfx_vrb_en,
   input  logic [NUM_CH-1:0] vsfx_ins_en,
   input  logic [NUM_CH-1:0] vsfx_vrt_en,
   output logic [NUM_CH-1:0] err_missing,
   output logic [NUM_CH-1:0] err_spurious,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  issue_count,
   output logic [CNT_W-1:0]  err_count
);

   // Expectation pipeline, held stage-major: exp_sr_reg[s][c] is bit s of
   // channel c's shift register. Every issue travels its own slot, so
   // back-to-back issues on one channel each keep their own expectation.
   logic [NUM_CH-1:0] exp_sr_reg [LATENCY];

   logic [NUM_CH-1:0] issue_vec;
   logic [NUM_CH-1:0] exp_vec;
   logic [NUM_CH-1:0] missing_vec;
   logic [NUM_CH-1:0] spurious_vec;

   assign issue_vec    = vsfx_vra_en & vsfx_vrb_en & vsfx_ins_en & {NUM_CH{chk_en}};
   assign exp_vec      = exp_sr_reg[LATENCY-1];
   // Missing stays active with chk_en low so in-flight issues are still checked.
   assign missing_vec  = exp_vec & ~vsfx_vrt_en;
   assign spurious_vec = vsfx_vrt_en & ~exp_vec & {NUM_CH{chk_en}};

   function automatic logic [CNT_W:0] popcnt(input logic [NUM_CH-1:0] v);
      logic [CNT_W:0] n;
      n = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         n = n + {{CNT_W{1'b0}}, v[i]};
      end
      return n;
   endfunction

   // Add with clamp at all-ones; one extra bit catches the overflow.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W:0]   b);
      logic [CNT_W+1:0] s;
      s = {2'b00, a} + {1'b0, b};
      if (s > {2'b00, {CNT_W{1'b1}}}) begin
         return {CNT_W{1'b1}};
      end
      return s[CNT_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         exp_sr_reg[0] <= '0;
      end else begin
         exp_sr_reg[0] <= issue_vec;
      end
   end

   generate
      for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (rst) begin
               exp_sr_reg[gi] <= '0;
            end else begin
               exp_sr_reg[gi] <= exp_sr_reg[gi-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         err_missing  <= '0;
         err_spurious <= '0;
         err_sticky   <= 1'b0;
         issue_count  <= '0;
         err_count    <= '0;
      end else begin
         err_missing  <= missing_vec;
         err_spurious <= spurious_vec;
         if (|(missing_vec | spurious_vec)) begin
            err_sticky <= 1'b1;
         end
         issue_count <= sat_add(issue_count, popcnt(issue_vec));
         // Missing and spurious are exclusive per channel, so OR then count.
         err_count   <= sat_add(err_count, popcnt(missing_vec | spurious_vec));
      end
   end

   generate
      if (MSG_EN != 0) begin : g_msg
`ifndef SYNTHESIS
         always @(posedge clk) begin
            if (!rst) begin
               for (int c = 0; c < NUM_CH; c++) begin
                  if (missing_vec[c]) begin
                     $error("altivec_wb_checker: ch%0d missing vrt_en at %0t", c, $time);
                  end
                  if (spurious_vec[c]) begin
                     $error("altivec_wb_checker: ch%0d spurious vrt_en at %0t", c, $time);
                  end
               end
            end
         end
`endif
      end
   endgenerate

endmodule

// File: tb/tb_altivec_wb_checker.sv
module tb_altivec_wb_checker;

   logic       clk;
   logic       rst;
   logic       chk_en;
   logic [1:0] vra_en;
   logic [1:0] vrb_en;
   logic [1:0] ins_en;
   logic [1:0] vrt_en;

   logic [1:0]  m1, s1, m2, s2, m3, s3, m4, s4;
   logic        st1, st2, st3, st4;
   logic [15:0] ic1, ec1, ic2, ec2, ic3, ec3;
   logic [3:0]  ic4, ec4;

   int checks = 0;
   int errors = 0;

   altivec_wb_checker #(.NUM_CH(2), .LATENCY(1), .CNT_W(16), .MSG_EN(0)) u_l1 (
      .clk(clk), .rst(rst), .chk_en(chk_en),
      .vsfx_vra_en(vra_en), .vsfx_vrb_en(vrb_en), .vsfx_ins_en(ins_en), .vsfx_vrt_en(vrt_en),
      .err_missing(m1), .err_spurious(s1), .err_sticky(st1), .issue_count(ic1), .err_count(ec1));

   altivec_wb_checker #(.NUM_CH(2), .LATENCY(2), .CNT_W(16), .MSG_EN(0)) u_l2 (
      .clk(clk), .rst(rst), .chk_en(chk_en),
      .vsfx_vra_en(vra_en), .vsfx_vrb_en(vrb_en), .vsfx_ins_en(ins_en), .vsfx_vrt_en(vrt_en),
      .err_missing(m2), .err_spurious(s2), .err_sticky(st2), .issue_count(ic2), .err_count(ec2));

   altivec_wb_checker #(.NUM_CH(2), .LATENCY(3), .CNT_W(16), .MSG_EN(0)) u_l3 (
      .clk(clk), .rst(rst), .chk_en(chk_en),
      .vsfx_vra_en(vra_en), .vsfx_vrb_en(vrb_en), .vsfx_ins_en(ins_en), .vsfx_vrt_en(vrt_en),
      .err_missing(m3), .err_spurious(s3), .err_sticky(st3), .issue_count(ic3), .err_count(ec3));

   altivec_wb_checker #(.NUM_CH(2), .LATENCY(4), .CNT_W(4), .MSG_EN(0)) u_l4 (
      .clk(clk), .rst(rst), .chk_en(chk_en),
      .vsfx_vra_en(vra_en), .vsfx_vrb_en(vrb_en), .vsfx_ins_en(ins_en), .vsfx_vrt_en(vrt_en),
      .err_missing(m4), .err_spurious(s4), .err_sticky(st4), .issue_count(ic4), .err_count(ec4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs set after tick are applied at the next edge; outputs read after
   // tick reflect the edge just taken.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      vra_en = 2'b00; vrb_en = 2'b00; ins_en = 2'b00; vrt_en = 2'b00;
   endtask

   task automatic issue(input logic [1:0] ch);
      vra_en = ch; vrb_en = ch; ins_en = ch;
   endtask

   task automatic do_reset();
      idle();
      chk_en = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; chk_en = 1'b1; idle();
      tick(); tick();
      checks++; if (m1 !== 2'b00) begin errors++; $display("FAIL reset_missing got %b exp 00", m1); end
      checks++; if (s1 !== 2'b00) begin errors++; $display("FAIL reset_spurious got %b exp 00", s1); end
      checks++; if (st1 !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", st1); end
      checks++; if (ic1 !== 16'd0) begin errors++; $display("FAIL reset_issue_count got %0d exp 0", ic1); end
      checks++; if (ec4 !== 4'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", ec4); end
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_basic();
      do_reset();
      issue(2'b01); tick();
      idle(); vrt_en = 2'b01; tick();
      checks++; if (m1 !== 2'b00) begin errors++; $display("FAIL basic_missing got %b exp 00", m1); end
      checks++; if (s1 !== 2'b00) begin errors++; $display("FAIL basic_spurious got %b exp 00", s1); end
      idle(); tick();
      checks++; if (ic1 !== 16'd1) begin errors++; $display("FAIL basic_issue_count got %0d exp 1", ic1); end
      checks++; if (ec1 !== 16'd0) begin errors++; $display("FAIL basic_err_count got %0d exp 0", ec1); end
      checks++; if (st1 !== 1'b0) begin errors++; $display("FAIL basic_sticky got %b exp 0", st1); end
      $display("test_basic done");
   endtask

   task automatic test_back_to_back();
      do_reset();
      issue(2'b10); tick(); tick(); tick();
      idle(); vrt_en = 2'b10; tick();
      checks++; if ((m3 | s3) !== 2'b00) begin errors++; $display("FAIL b2b_first got %b/%b exp 00/00", m3, s3); end
      tick();
      checks++; if ((m3 | s3) !== 2'b00) begin errors++; $display("FAIL b2b_second got %b/%b exp 00/00", m3, s3); end
      vrt_en = 2'b00; tick();
      checks++; if (m3 !== 2'b10) begin errors++; $display("FAIL b2b_missing got %b exp 10", m3); end
      checks++; if (st3 !== 1'b1) begin errors++; $display("FAIL b2b_sticky got %b exp 1", st3); end
      tick();
      checks++; if (m3 !== 2'b00) begin errors++; $display("FAIL b2b_pulse_end got %b exp 00", m3); end
      checks++; if (ec3 !== 16'd1) begin errors++; $display("FAIL b2b_err_count got %0d exp 1", ec3); end
      checks++; if (ic3 !== 16'd3) begin errors++; $display("FAIL b2b_issue_count got %0d exp 3", ic3); end
      checks++; if (st3 !== 1'b1) begin errors++; $display("FAIL b2b_sticky_hold got %b exp 1", st3); end
      $display("test_back_to_back done");
   endtask

   task automatic test_spurious();
      do_reset();
      vrt_en = 2'b01; tick();
      checks++; if (s1 !== 2'b01) begin errors++; $display("FAIL spur_pulse got %b exp 01", s1); end
      checks++; if (m1 !== 2'b00) begin errors++; $display("FAIL spur_missing got %b exp 00", m1); end
      idle(); tick();
      checks++; if (s1 !== 2'b00) begin errors++; $display("FAIL spur_pulse_end got %b exp 00", s1); end
      chk_en = 1'b0; vrt_en = 2'b01; tick();
      checks++; if (s1 !== 2'b00) begin errors++; $display("FAIL spur_chk_off got %b exp 00", s1); end
      checks++; if (ec1 !== 16'd1) begin errors++; $display("FAIL spur_err_count got %0d exp 1", ec1); end
      chk_en = 1'b1; idle();
      $display("test_spurious done");
   endtask

   task automatic test_early();
      do_reset();
      issue(2'b01); tick();
      idle(); vrt_en = 2'b01; tick();
      checks++; if (s2 !== 2'b01) begin errors++; $display("FAIL early_spurious got %b exp 01", s2); end
      checks++; if (m2 !== 2'b00) begin errors++; $display("FAIL early_no_missing got %b exp 00", m2); end
      vrt_en = 2'b00; tick();
      checks++; if (m2 !== 2'b01) begin errors++; $display("FAIL early_missing got %b exp 01", m2); end
      checks++; if (s2 !== 2'b00) begin errors++; $display("FAIL early_spur_end got %b exp 00", s2); end
      tick();
      checks++; if (ec2 !== 16'd2) begin errors++; $display("FAIL early_err_count got %0d exp 2", ec2); end
      $display("test_early done");
   endtask

   task automatic test_chk_drop();
      do_reset();
      issue(2'b10); tick();
      idle(); chk_en = 1'b0; tick();
      tick();
      checks++; if (m2 !== 2'b10) begin errors++; $display("FAIL chkdrop_missing got %b exp 10", m2); end
      checks++; if (ic2 !== 16'd1) begin errors++; $display("FAIL chkdrop_issue_count got %0d exp 1", ic2); end
      issue(2'b11); tick();
      checks++; if (ic2 !== 16'd1) begin errors++; $display("FAIL chkdrop_no_issue got %0d exp 1", ic2); end
      chk_en = 1'b1; idle();
      $display("test_chk_drop done");
   endtask

   task automatic test_rst_mid();
      logic [1:0] any_m;
      do_reset();
      issue(2'b01); tick();
      idle(); tick();
      rst = 1'b1; tick();
      rst = 1'b0;
      checks++; if ({m4, s4, st4, ic4, ec4} !== 13'd0) begin errors++; $display("FAIL rstmid_outputs got %h exp 0", {m4, s4, st4, ic4, ec4}); end
      any_m = 2'b00;
      for (int i = 0; i < 5; i++) begin
         tick();
         any_m = any_m | m4;
      end
      checks++; if (any_m !== 2'b00) begin errors++; $display("FAIL rstmid_no_missing got %b exp 00", any_m); end
      $display("test_rst_mid done");
   endtask

   task automatic test_saturation();
      do_reset();
      issue(2'b01);
      for (int i = 0; i < 20; i++) tick();
      idle();
      for (int i = 0; i < 6; i++) tick();
      checks++; if (ec4 !== 4'd15) begin errors++; $display("FAIL sat_err_count got %0d exp 15", ec4); end
      checks++; if (ic4 !== 4'd15) begin errors++; $display("FAIL sat_issue_count got %0d exp 15", ic4); end
      checks++; if (st4 !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b exp 1", st4); end
      $display("test_saturation done");
   endtask

   task automatic test_dual();
      do_reset();
      issue(2'b11); tick();
      idle(); vrt_en = 2'b11; tick();
      checks++; if ((m1 | s1) !== 2'b00) begin errors++; $display("FAIL dual_clean got %b/%b exp 00/00", m1, s1); end
      checks++; if (ic1 !== 16'd2) begin errors++; $display("FAIL dual_issue_count got %0d exp 2", ic1); end
      vrt_en = 2'b11; tick();
      checks++; if (s1 !== 2'b11) begin errors++; $display("FAIL dual_spurious got %b exp 11", s1); end
      checks++; if (ec1 !== 16'd2) begin errors++; $display("FAIL dual_err_count got %0d exp 2", ec1); end
      idle();
      $display("test_dual done");
   endtask

   initial begin
      rst = 1'b1; chk_en = 1'b0; idle();
      test_reset();
      test_basic();
      test_back_to_back();
      test_spurious();
      test_early();
      test_chk_drop();
      test_rst_mid();
      test_saturation();
      test_dual();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/altivec_wb_checker.md
# altivec_wb_checker

Parametrised multi-channel write-back protocol checker for the vector simple fixed-point (VSFX) datapath. For every channel it tracks issued instructions (VRA, VRB and instruction enables all high) through a configurable-latency expectation pipeline. It flags a missing or spurious VRT write-enable. It also keeps saturating issue and error counters. It is bound beside the VSFX unit in the verification environment, is synthesizable for emulation, and reports to the bench through pulse, sticky and count outputs.

## Interface
- NUM_CH, 2, number of independent issue/write-back channels (1..8)
- LATENCY, 1, cycles from issue to required vrt_en (1..8)
- CNT_W, 16, width of issue and error counters
- MSG_EN, 1, 1 = emit $error text in simulation on each flagged error; 0 = silent
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- chk_en  in  1  global check enable
- vsfx_vra_en  in  NUM_CH  per-channel VRA read enable
- vsfx_vrb_en  in  NUM_CH  per-channel VRB read enable
- vsfx_ins_en  in  NUM_CH  per-channel instruction valid
- vsfx_vrt_en  in  NUM_CH  per-channel VRT write enable
- err_missing  out  NUM_CH  1-cycle pulse, expected vrt_en absent
- err_spurious  out  NUM_CH  1-cycle pulse, vrt_en with no expectation
- err_sticky  out  1  set on any error, cleared only by rst
- issue_count  out  CNT_W  saturating count of recorded issues
- err_count  out  CNT_W  saturating count of flagged errors

## Operation
- Issue on channel c at cycle T: vra_en[c] & vrb_en[c] & ins_en[c] & chk_en.
- Per channel, a LATENCY-deep shift register `exp_sr`. Bit 0 is loaded with the issue term. It shifts every cycle. The tail bit `exp[c]` is the expectation for the current cycle.
- The shift register is not a counter. Back-to-back issues each carry their own expectation, so one issue per cycle per channel is supported.
- Check at cycle T, compared combinationally and registered to the outputs at T+1:
  - missing[c] = exp[c] & ~vrt_en[c]. This check is always active, including while chk_en is low, so in-flight issues are still checked.
  - spurious[c] = vrt_en[c] & ~exp[c] & chk_en.
- err_missing and err_spurious are registered pulses, asserted for one cycle only.
- err_sticky is set at T+1 if any bit of either error vector is set at T.
- issue_count adds popcount(issue vector) each cycle and saturates at 2^CNT_W−1.
- err_count adds popcount(missing | spurious) each cycle and saturates at 2^CNT_W−1.
  - Missing and spurious are mutually exclusive per channel, so the per-cycle increment is at most NUM_CH.
- With MSG_EN=1, a simulation-only block prints channel number, error type and $time on each error. This block is excluded from synthesis.
- Channels are fully independent. No cross-channel ordering is checked.

## Timing
- Reset value of every output is 0. All exp_sr bits are cleared.
- rst has priority over all other activity. Asserting rst mid-operation discards all in-flight expectations. Those issues are not flagged as missing.
- After rst deasserts, a vrt_en arriving within LATENCY cycles with no new issue is flagged spurious if chk_en=1. This is intentional.
- Issue at cycle T requires vrt_en at exactly T+LATENCY. Any error appears on the outputs at T+LATENCY+1.
- Early or late vrt_en produces two errors: a spurious error at the wrong cycle and a missing error at T+LATENCY.
- Simultaneous issue and check on the same channel in the same cycle is legal. Both are processed.
- At counter saturation the counter holds at all-ones. err_sticky and the pulse outputs are unaffected.
- chk_en toggling: issues are recorded only while chk_en=1. An expectation recorded before chk_en falls is still checked for missing.

## Test plan
- NUM_CH=2, LATENCY=1: issue on ch0 at cycle 5, vrt_en[0]=1 at cycle 6 -> no error pulses; issue_count=1, err_count=0, err_sticky=0.
- LATENCY=3: ch1 issues on cycles 10, 11 and 12; vrt_en[1] high on cycles 13 and 14 and low on 15 -> err_missing[1] pulses at cycle 16 only; err_count=1; err_sticky=1 from cycle 16.
- LATENCY=1: vrt_en[0]=1 at cycle 20 with no issue, chk_en=1 -> err_spurious[0] at cycle 21. Repeat with chk_en=0 -> no pulse.
- LATENCY=2: ch0 issue at cycle 30, vrt_en[0] at cycle 31 instead of 32 -> err_spurious[0] at cycle 32, err_missing[0] at cycle 33; err_count=2.
- LATENCY=4: issue at cycle 40, rst high at cycle 42 for one cycle, no vrt_en -> no err_missing; all outputs 0 at cycle 43.
- CNT_W=4: 20 missing errors on ch0 -> err_count holds at 15; both channels erroring in the same cycle -> err_count increments by 2 in that cycle.
